// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file.
// Optional feature macro: REGFILE_SB_BYPASS_EN (same-cycle write-to-read bypass).
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 2;

  localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: zero/enable/reset gating and, when
// REGFILE_SB_BYPASS_EN is defined, forwarding of a same-cycle write.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_WR = DEF_NUM_WR
) (
  input  logic                     rst_i,
  input  logic                     re_i,
  input  logic [ADDR_W-1:0]        raddr_i,
  input  logic [DATA_W-1:0]        st_data_i,
  input  logic                     st_pend_i,
`ifdef REGFILE_SB_BYPASS_EN
  input  logic [NUM_WR-1:0]        we_i,
  input  logic [NUM_WR*ADDR_W-1:0] waddr_i,
  input  logic [NUM_WR*DATA_W-1:0] wdata_i,
`endif
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     rbusy_o
);

  // Select stored value, or a forwarded write (higher port index wins).
  always_comb begin
    rdata_o = DATA_W'(ZERO_WORD);
    rbusy_o = 1'b0;
    if (!rst_i && re_i && (raddr_i != '0)) begin
      rdata_o = st_data_i;
      rbusy_o = st_pend_i;
`ifdef REGFILE_SB_BYPASS_EN
      for (int i = 0; i < NUM_WR; i++) begin
        if (we_i[i] && (waddr_i[i*ADDR_W +: ADDR_W] == raddr_i)) begin
          rdata_o = wdata_i[i*DATA_W +: DATA_W];
          rbusy_o = 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with a pending-write scoreboard.
// Register 0 reads as zero and never becomes pending.
// Optional macro REGFILE_SB_BYPASS_EN forwards same-cycle writes to reads.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     issue_v,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

  // Next state: writes in ascending port order so the higher port wins;
  // writes clear pending, issue sets it afterwards (issue wins), flush clears all.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (we[i]) begin
        regs_d[waddr[i*ADDR_W +: ADDR_W]] = wdata[i*DATA_W +: DATA_W];
        pend_d[waddr[i*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (issue_v) pend_d[issue_addr] = 1'b1;
    if (flush)   pend_d = '0;
    // Anything aimed at r0 above is simply overridden here.
    regs_d[0] = DATA_W'(ZERO_WORD);
    pend_d[0] = 1'b0;
  end

  // Population count of the next pending vector.
  always_comb begin
    busy_cnt_d = '0;
    for (int k = 0; k < DEPTH; k++) busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(pend_d[k]);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= DATA_W'(ZERO_WORD);
      pend_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      pend_q     <= pend_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[j*ADDR_W +: ADDR_W];

    rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_rd (
      .rst_i     (rst),
      .re_i      (re[j]),
      .raddr_i   (ra),
      .st_data_i (regs_q[ra]),
      .st_pend_i (pend_q[ra]),
`ifdef REGFILE_SB_BYPASS_EN
      .we_i      (we),
      .waddr_i   (waddr),
      .wdata_i   (wdata),
`endif
      .rdata_o   (rdata[j*DATA_W +: DATA_W]),
      .rbusy_o   (rbusy[j])
    );
  end

endmodule
